// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the IF-stage branch predictor: counter states,
// EX resolution status codes and the init/run FSM states.
package branch_predictor_pkg;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   localparam logic [1:0] PS_MISS_NT = 2'd0;
   localparam logic [1:0] PS_MISS_T  = 2'd1;
   localparam logic [1:0] PS_HIT_NT  = 2'd2;
   localparam logic [1:0] PS_HIT_T   = 2'd3;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_t;

   // The branch was actually taken when it was mispredicted NT or correctly predicted T.
   function automatic logic status_taken(input logic [1:0] ps);
      return (ps == PS_MISS_NT) || (ps == PS_HIT_T);
   endfunction

   function automatic logic status_mispredict(input logic [1:0] ps);
      return (ps == PS_MISS_NT) || (ps == PS_MISS_T);
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step: increments on taken, decrements
// otherwise, clamping at strong-taken / strong-not-taken.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (taken) begin
         if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
      end else begin
         if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BHT of 2-bit counters plus a direct-mapped
// BTB, trained from EX resolution, with an init sweep after reset.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   IF_pc,
   output logic [1:0]        IF_branch_prediction,
   output logic              IF_predict_taken,
   output logic [XLEN-1:0]   IF_predicted_target,
   input  logic              EX_Branch,
   input  logic [XLEN-1:0]   EX_pc,
   input  logic [XLEN-1:0]   EX_branch_target,
   input  logic [1:0]        prediction_status,
   output logic              predictor_ready,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam int unsigned TAG_W   = XLEN - INDEX_BITS - 2;

   logic [1:0]       bht        [ENTRIES];
   logic             btb_valid  [ENTRIES];
   logic [TAG_W-1:0] btb_tag    [ENTRIES];
   logic [XLEN-1:0]  btb_target [ENTRIES];

   bp_state_t             state;
   logic [INDEX_BITS-1:0] sweep;

   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_W-1:0]      if_tag;
   logic [INDEX_BITS-1:0] ex_idx;
   logic [TAG_W-1:0]      ex_tag;
   logic                  ex_taken;
   logic [1:0]            ex_cnt_next;
   logic                  if_hit;
   logic [3:0]            unused_pc_bits;

   assign if_idx   = IF_pc[INDEX_BITS+1:2];
   assign if_tag   = IF_pc[XLEN-1:INDEX_BITS+2];
   assign ex_idx   = EX_pc[INDEX_BITS+1:2];
   assign ex_tag   = EX_pc[XLEN-1:INDEX_BITS+2];
   assign ex_taken = status_taken(prediction_status);
   assign unused_pc_bits = {IF_pc[1:0], EX_pc[1:0]};

   sat_counter2 u_sat_counter2 (
      .cnt      (bht[ex_idx]),
      .taken    (ex_taken),
      .cnt_next (ex_cnt_next)
   );

   // Lookup reads the table as it stands this cycle; a same-index update lands next cycle.
   always_comb begin
      IF_branch_prediction = CNT_WNT;
      IF_predict_taken     = 1'b0;
      IF_predicted_target  = '0;
      if_hit               = 1'b0;
      if (state == ST_RUN) begin
         if_hit               = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
         IF_branch_prediction = bht[if_idx];
         IF_predict_taken     = bht[if_idx][1] && if_hit;
         IF_predicted_target  = if_hit ? btb_target[if_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_INIT;
         sweep            <= '0;
         predictor_ready  <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               bht[sweep]       <= CNT_WNT;
               btb_valid[sweep] <= 1'b0;
               sweep            <= sweep + 1'b1;
               if (sweep == '1) begin
                  state           <= ST_RUN;
                  predictor_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (EX_Branch) begin
                  bht[ex_idx] <= ex_cnt_next;
                  if (ex_taken) begin
                     btb_valid[ex_idx]  <= 1'b1;
                     btb_tag[ex_idx]    <= ex_tag;
                     btb_target[ex_idx] <= EX_branch_target;
                  end
                  branch_count <= branch_count + 1'b1;
                  if (status_mispredict(prediction_status))
                     mispredict_count <= mispredict_count + 1'b1;
               end
            end
            default: begin
               state <= ST_INIT;
               sweep <= '0;
            end
         endcase
      end
   end

endmodule
